// File: rtl/button_debouncer_if.sv
// Signal bundle between the push-button pad conditioner and its consumer.
// BUTTON_DEBOUNCER_LONG_PRESS_EN adds the long_press strobe.
interface button_debouncer_if;
   logic       btn_raw;
   logic       count_clr;
   logic       btn_level;
   logic       press_pulse;
   logic       release_pulse;
   logic [7:0] press_count;
`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
   logic       long_press;
`endif

   modport master (
`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
      input  long_press,
`endif
      output btn_raw,
      output count_clr,
      input  btn_level,
      input  press_pulse,
      input  release_pulse,
      input  press_count
   );

   modport slave (
`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
      output long_press,
`endif
      input  btn_raw,
      input  count_clr,
      output btn_level,
      output press_pulse,
      output release_pulse,
      output press_count
   );
endinterface

// File: rtl/button_debouncer.sv
// Push-button conditioner: 2-flop synchroniser, stable-time debounce FSM, press/release pulses
// and a wrapping press counter. Optional long-press strobe under BUTTON_DEBOUNCER_LONG_PRESS_EN.
module button_debouncer #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 20,
   parameter int ACTIVE_LOW      = 1
`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
   ,
   parameter int LONG_CYCLES     = 50000000
`endif
) (
   input  logic                clk,
   input  logic                reset_n,
   button_debouncer_if.slave   bus_if
);

   typedef enum logic [1:0] {
      RELEASED    = 2'd0,
      CHK_PRESS   = 2'd1,
      PRESSED     = 2'd2,
      CHK_RELEASE = 2'd3
   } state_e;

   localparam logic             POL      = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sync1_q, sync2_q;
   logic             level_q, level_d;
   logic             press_q, press_d;
   logic             rel_q, rel_d;
   logic [7:0]       count_q, count_d;
   logic             btn_in_s;
   logic             accept_press_s;
   logic             accept_release_s;

   assign btn_in_s = bus_if.btn_raw ^ POL;

   // Synchroniser and all registered state/outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         state_q <= RELEASED;
         cnt_q   <= CNT_ZERO;
         level_q <= 1'b0;
         press_q <= 1'b0;
         rel_q   <= 1'b0;
         count_q <= 8'd0;
      end else begin
         sync1_q <= btn_in_s;
         sync2_q <= sync1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         press_q <= press_d;
         rel_q   <= rel_d;
         count_q <= count_d;
      end
   end

   // Debounce FSM next state; acceptance is registered into the level and pulse flops.
   always_comb begin
      state_d          = state_q;
      cnt_d            = cnt_q;
      level_d          = level_q;
      press_d          = 1'b0;
      rel_d            = 1'b0;
      accept_press_s   = 1'b0;
      accept_release_s = 1'b0;
      case (state_q)
         RELEASED: begin
            level_d = 1'b0;
            if (sync2_q) begin
               state_d = CHK_PRESS;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d   = CNT_ZERO;
            end
         end
         CHK_PRESS: begin
            if (!sync2_q) begin
               state_d = RELEASED;
               cnt_d   = CNT_ZERO;
            end else if (cnt_q == DEB_LAST) begin
               state_d        = PRESSED;
               cnt_d          = CNT_ZERO;
               level_d        = 1'b1;
               press_d        = 1'b1;
               accept_press_s = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         PRESSED: begin
            level_d = 1'b1;
            if (!sync2_q) begin
               state_d = CHK_RELEASE;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d   = CNT_ZERO;
            end
         end
         CHK_RELEASE: begin
            if (sync2_q) begin
               state_d = PRESSED;
               cnt_d   = CNT_ZERO;
            end else if (cnt_q == DEB_LAST) begin
               state_d          = RELEASED;
               cnt_d            = CNT_ZERO;
               level_d          = 1'b0;
               rel_d            = 1'b1;
               accept_release_s = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = RELEASED;
            cnt_d   = CNT_ZERO;
            level_d = 1'b0;
         end
      endcase
   end

   // A clear coinciding with an accepted press still counts that press.
   always_comb begin
      count_d = (bus_if.count_clr ? 8'd0 : count_q) + (accept_press_s ? 8'd1 : 8'd0);
   end

   assign bus_if.btn_level     = level_q;
   assign bus_if.press_pulse   = press_q;
   assign bus_if.release_pulse = rel_q;
   assign bus_if.press_count   = count_q;

`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
   localparam int              HOLD_W    = $clog2(LONG_CYCLES + 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              long_q, long_d;

   // Hold-time counter and long-press strobe registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hold_q <= '0;
         long_q <= 1'b0;
      end else begin
         hold_q <= hold_d;
         long_q <= long_d;
      end
   end

   // Saturating at HOLD_MAX gives at most one strobe per press; bounce back to PRESSED keeps the count.
   always_comb begin
      hold_d = hold_q;
      long_d = 1'b0;
      if (accept_press_s || accept_release_s) begin
         hold_d = '0;
      end else if ((state_q == PRESSED) || (state_q == CHK_RELEASE)) begin
         if (hold_q != HOLD_MAX) begin
            hold_d = hold_q + HOLD_ONE;
            long_d = (hold_q == HOLD_LAST);
         end else begin
            hold_d = hold_q;
         end
      end else begin
         hold_d = hold_q;
      end
   end

   assign bus_if.long_press = long_q;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Directed self-checking bench for button_debouncer (DEBOUNCE_CYCLES=4, ACTIVE_LOW=1).
// Long-press checks compile in when BUTTON_DEBOUNCER_LONG_PRESS_EN is defined.
module tb_button_debouncer;

   logic clk = 1'b0;
   logic reset_n;
   int   n_checks = 0;
   int   n_errors = 0;
   int   n_press_seen = 0;
   int   exp_presses = 0;
   logic prev_pulse = 1'b0;

   button_debouncer_if bif ();

   button_debouncer #(
      .DEBOUNCE_CYCLES (4),
      .CNT_W           (3),
      .ACTIVE_LOW      (1)
`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
      ,
      .LONG_CYCLES     (10)
`endif
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus_if  (bif)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press_release();
      bif.btn_raw = 1'b0;
      repeat (7) tick();
      bif.btn_raw = 1'b1;
      repeat (7) tick();
      exp_presses++;
   endtask

   // Pulse sanity: exclusive and never on two consecutive cycles.
   always @(negedge clk) begin
      if (bif.press_pulse) begin
         n_press_seen++;
         check_eq("pulse_excl", {31'd0, bif.release_pulse}, 32'd0);
      end
      if (bif.press_pulse || bif.release_pulse) begin
         check_eq("pulse_back2back", {31'd0, prev_pulse}, 32'd0);
      end
      prev_pulse = bif.press_pulse | bif.release_pulse;
   end

   initial begin
      reset_n       = 1'b0;
      bif.btn_raw   = 1'b1;
      bif.count_clr = 1'b0;
      repeat (3) tick();
      check_eq("rst_level", {31'd0, bif.btn_level}, 32'd0);
      check_eq("rst_count", {24'd0, bif.press_count}, 32'd0);
      reset_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_eq("idle_level", {31'd0, bif.btn_level}, 32'd0);
         check_eq("idle_press", {31'd0, bif.press_pulse}, 32'd0);
         check_eq("idle_count", {24'd0, bif.press_count}, 32'd0);
      end

      // Clean press: edge k samples, acceptance after edge k+5.
      bif.btn_raw = 1'b0;
      tick();
      for (int i = 1; i <= 4; i++) begin
         tick();
         check_eq("press_early", {31'd0, bif.btn_level}, 32'd0);
      end
      tick();
      check_eq("press_level", {31'd0, bif.btn_level}, 32'd1);
      check_eq("press_pulse", {31'd0, bif.press_pulse}, 32'd1);
      check_eq("press_count", {24'd0, bif.press_count}, 32'd1);
      tick();
      check_eq("press_pulse_end", {31'd0, bif.press_pulse}, 32'd0);
      check_eq("press_level_hold", {31'd0, bif.btn_level}, 32'd1);
      exp_presses++;

      // Clean release, same latency.
      bif.btn_raw = 1'b1;
      tick();
      for (int i = 1; i <= 4; i++) begin
         tick();
         check_eq("rel_early", {31'd0, bif.btn_level}, 32'd1);
      end
      tick();
      check_eq("rel_level", {31'd0, bif.btn_level}, 32'd0);
      check_eq("rel_pulse", {31'd0, bif.release_pulse}, 32'd1);
      tick();
      check_eq("rel_pulse_end", {31'd0, bif.release_pulse}, 32'd0);

      // Bounce: low 3, high 1, low 2, then high.
      bif.btn_raw = 1'b0; repeat (3) tick();
      bif.btn_raw = 1'b1; tick();
      bif.btn_raw = 1'b0; repeat (2) tick();
      bif.btn_raw = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check_eq("bounce_level", {31'd0, bif.btn_level}, 32'd0);
         check_eq("bounce_pulse", {31'd0, bif.press_pulse}, 32'd0);
      end
      check_eq("bounce_count", {24'd0, bif.press_count}, 32'd1);

      // count_clr alone.
      bif.count_clr = 1'b1; tick(); bif.count_clr = 1'b0;
      check_eq("clr_alone", {24'd0, bif.press_count}, 32'd0);

      // count_clr coinciding with acceptance at count 7.
      repeat (7) press_release();
      check_eq("count7", {24'd0, bif.press_count}, 32'd7);
      bif.btn_raw = 1'b0;
      repeat (5) tick();
      bif.count_clr = 1'b1;
      tick();
      bif.count_clr = 1'b0;
      check_eq("clr_accept_pulse", {31'd0, bif.press_pulse}, 32'd1);
      check_eq("clr_accept_count", {24'd0, bif.press_count}, 32'd1);
      exp_presses++;
      bif.btn_raw = 1'b1;
      repeat (7) tick();
      bif.count_clr = 1'b1; tick(); bif.count_clr = 1'b0;
      check_eq("clr_alone2", {24'd0, bif.press_count}, 32'd0);

      // Wrap 255 -> 0.
      repeat (255) press_release();
      check_eq("count255", {24'd0, bif.press_count}, 32'd255);
      press_release();
      check_eq("count_wrap", {24'd0, bif.press_count}, 32'd0);
      press_release();
      check_eq("count_after_wrap", {24'd0, bif.press_count}, 32'd1);

      // Reset while in CHK_PRESS, button still held through reset.
      bif.btn_raw = 1'b0;
      repeat (3) tick();
      reset_n = 1'b0;
      #1;
      check_eq("midrst_count", {24'd0, bif.press_count}, 32'd0);
      check_eq("midrst_level", {31'd0, bif.btn_level}, 32'd0);
      repeat (2) tick();
      reset_n = 1'b1;
      tick();
      for (int i = 1; i <= 4; i++) begin
         tick();
         check_eq("postrst_early", {31'd0, bif.press_pulse}, 32'd0);
      end
      tick();
      check_eq("postrst_pulse", {31'd0, bif.press_pulse}, 32'd1);
      check_eq("postrst_count", {24'd0, bif.press_count}, 32'd1);
      exp_presses++;

`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
      for (int i = 1; i <= 9; i++) begin
         tick();
         check_eq("long_early", {31'd0, bif.long_press}, 32'd0);
      end
      tick();
      check_eq("long_pulse", {31'd0, bif.long_press}, 32'd1);
      tick();
      check_eq("long_end", {31'd0, bif.long_press}, 32'd0);
      for (int i = 0; i < 15; i++) begin
         tick();
         check_eq("long_once", {31'd0, bif.long_press}, 32'd0);
      end
`else
      repeat (3) tick();
`endif
      bif.btn_raw = 1'b1;
      repeat (7) tick();
      check_eq("final_level", {31'd0, bif.btn_level}, 32'd0);
      check_eq("press_pulses_total", n_press_seen, exp_presses);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
